// File: rtl/stark_branch_scheduler_pkg.sv
// Shared types for the branch-station issue scheduler: ROB index,
// watchdog counter and per-station occupancy state.
package stark_branch_scheduler_pkg;

    localparam int ROB_NDX_W = 5;
    localparam int WDOG_W    = 6;

    typedef logic [ROB_NDX_W-1:0] rob_ndx_t;
    typedef logic [WDOG_W-1:0]    wdog_cnt_t;

    typedef enum logic {
        BS_IDLE = 1'b0,
        BS_BUSY = 1'b1
    } bs_state_t;

endpackage

// File: rtl/stark_branch_scheduler_if.sv
// Bundle between the scheduler, the ROB and the branch stations. The
// scheduler sits on the slave side; ROB/stations drive the master side.
interface stark_branch_scheduler_if #(
    parameter int NBS         = 2,
    parameter int ROB_ENTRIES = 32
);
    import stark_branch_scheduler_pkg::*;

    rob_ndx_t               head;
    logic [ROB_ENTRIES-1:0] brrdy;
    logic                   flush;
    logic [NBS-1:0]         bs_done;

    logic [NBS-1:0]         issue;
    rob_ndx_t [NBS-1:0]     rndx;
    logic [NBS-1:0]         rndxv;
    logic [NBS-1:0]         bs_idle_oh;
    logic [ROB_ENTRIES-1:0] issued;
    logic                   tmo_err;

    modport master (
        output head, brrdy, flush, bs_done,
        input  issue, rndx, rndxv, bs_idle_oh, issued, tmo_err
    );

    modport slave (
        input  head, brrdy, flush, bs_done,
        output issue, rndx, rndxv, bs_idle_oh, issued, tmo_err
    );

endinterface

// File: rtl/stark_branch_scheduler_age_select.sv
// Combinational age selector: rotates ready/pending by the ROB head and
// returns the NBS oldest non-pending ready entries, oldest first.
module stark_branch_scheduler_age_select
    import stark_branch_scheduler_pkg::*;
#(
    parameter int NBS         = 2,
    parameter int ROB_ENTRIES = 32
) (
    input  rob_ndx_t               head_i,
    input  logic [ROB_ENTRIES-1:0] ready_i,
    input  logic [ROB_ENTRIES-1:0] pend_i,
    output rob_ndx_t [NBS-1:0]     ndx_o,
    output logic [NBS-1:0]         vld_o
);

    logic [ROB_ENTRIES-1:0] rotReady;
    logic [ROB_ENTRIES-1:0] rotPend;

    // After rotation bit 0 is the head entry, so lower bits are older.
    assign rotReady = (ready_i >> head_i) | (ready_i << (ROB_ENTRIES - int'(head_i)));
    assign rotPend  = (pend_i  >> head_i) | (pend_i  << (ROB_ENTRIES - int'(head_i)));

    always_comb begin
        logic [ROB_ENTRIES-1:0] avail;
        logic                   found;
        avail = rotReady & ~rotPend;
        found = 1'b0;
        ndx_o = '0;
        vld_o = '0;
        for (int n = 0; n < NBS; n++) begin
            found = 1'b0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                if (!found && avail[i]) begin
                    found    = 1'b1;
                    avail[i] = 1'b0;
                    ndx_o[n] = rob_ndx_t'(i) + head_i;
                end
            end
            vld_o[n] = found;
        end
    end

endmodule

// File: rtl/stark_branch_scheduler.sv
// Branch-station issue scheduler: oldest-first selection from the ROB,
// per-station IDLE/BUSY tracking with a watchdog, registered issue outputs.
module stark_branch_scheduler
    import stark_branch_scheduler_pkg::*;
#(
    parameter int NBS         = 2,
    parameter int ROB_ENTRIES = 32,
    parameter int TMO         = 63
) (
    input  logic                    clk,
    input  logic                    rst,
    stark_branch_scheduler_if.slave bus
);

    localparam wdog_cnt_t TMO_LAST = wdog_cnt_t'(TMO - 1);

    bs_state_t              state_q [NBS];
    bs_state_t              state_d [NBS];
    wdog_cnt_t              cnt_q   [NBS];
    wdog_cnt_t              cnt_d   [NBS];
    logic [NBS-1:0]         issue_q, issue_d;
    rob_ndx_t [NBS-1:0]     rndx_q, rndx_d;
    logic [ROB_ENTRIES-1:0] issued_q, issued_d;
    logic                   tmoErr_q, tmoErr_d;
    logic [ROB_ENTRIES-1:0] heldMask;
    rob_ndx_t [NBS-1:0]     candNdx;
    logic [NBS-1:0]         candVld;

    // Entries owned by a busy station are blocked from selection; this covers
    // last cycle's issues while the ROB issued flag catches up, and also any
    // stale ready bit for an entry still executing.
    always_comb begin
        heldMask = '0;
        for (int k = 0; k < NBS; k++) begin
            if (state_q[k] == BS_BUSY) begin
                heldMask[rndx_q[k]] = 1'b1;
            end
        end
    end

    stark_branch_scheduler_age_select #(
        .NBS         (NBS),
        .ROB_ENTRIES (ROB_ENTRIES)
    ) u_age_select (
        .head_i  (bus.head),
        .ready_i (bus.brrdy),
        .pend_i  (heldMask),
        .ndx_o   (candNdx),
        .vld_o   (candVld)
    );

    // The n-th oldest candidate goes to the n-th idle station in index order.
    always_comb begin
        int rank;
        rank     = 0;
        issue_d  = '0;
        rndx_d   = rndx_q;
        issued_d = '0;
        for (int k = 0; k < NBS; k++) begin
            if (!bus.flush && state_q[k] == BS_IDLE) begin
                for (int n = 0; n < NBS; n++) begin
                    if (rank == n && candVld[n]) begin
                        issue_d[k]          = 1'b1;
                        rndx_d[k]           = candNdx[n];
                        issued_d[candNdx[n]] = 1'b1;
                    end
                end
                rank = rank + 1;
            end
        end
    end

    // Done takes priority over watchdog expiry; flush overrides everything.
    always_comb begin
        tmoErr_d = 1'b0;
        for (int k = 0; k < NBS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (bus.flush) begin
                state_d[k] = BS_IDLE;
                cnt_d[k]   = '0;
            end else begin
                case (state_q[k])
                    BS_IDLE: begin
                        if (issue_d[k]) begin
                            state_d[k] = BS_BUSY;
                            cnt_d[k]   = '0;
                        end
                    end
                    BS_BUSY: begin
                        if (bus.bs_done[k]) begin
                            state_d[k] = BS_IDLE;
                            cnt_d[k]   = '0;
                        end else if (cnt_q[k] == TMO_LAST) begin
                            state_d[k] = BS_IDLE;
                            cnt_d[k]   = '0;
                            tmoErr_d   = 1'b1;
                        end else begin
                            cnt_d[k] = cnt_q[k] + wdog_cnt_t'(1);
                        end
                    end
                    default: begin
                        state_d[k] = BS_IDLE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBS; k++) begin
                state_q[k] <= BS_IDLE;
                cnt_q[k]   <= '0;
            end
            issue_q  <= '0;
            rndx_q   <= '0;
            issued_q <= '0;
            tmoErr_q <= 1'b0;
        end else begin
            for (int k = 0; k < NBS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            issue_q  <= issue_d;
            rndx_q   <= rndx_d;
            issued_q <= issued_d;
            tmoErr_q <= tmoErr_d;
        end
    end

    assign bus.issue   = issue_q;
    assign bus.rndx    = rndx_q;
    assign bus.issued  = issued_q;
    assign bus.tmo_err = tmoErr_q;

    for (genvar k = 0; k < NBS; k++) begin : g_status
        assign bus.rndxv[k]      = (state_q[k] == BS_BUSY);
        assign bus.bs_idle_oh[k] = (state_q[k] == BS_IDLE);
    end

endmodule

// File: tb/tb_stark_branch_scheduler.sv
// Bench for stark_branch_scheduler: directed scenarios plus a randomized
// run against an age-ordered reference model of the station pool.
module tb_stark_branch_scheduler;
    import stark_branch_scheduler_pkg::*;

    localparam int NBS = 2;
    localparam int ROB = 32;
    localparam int TMO = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    stark_branch_scheduler_if #(.NBS(NBS), .ROB_ENTRIES(ROB)) ifc ();

    stark_branch_scheduler #(
        .NBS         (NBS),
        .ROB_ENTRIES (ROB),
        .TMO         (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst         = 1'b1;
        ifc.head    = '0;
        ifc.brrdy   = '0;
        ifc.flush   = 1'b0;
        ifc.bs_done = '0;
        stepClock();
        stepClock();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        compared++;
        if (ifc.bs_idle_oh !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: got %b expected 11", ifc.bs_idle_oh);
        end
        compared++;
        if (ifc.issue !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_issue: got %b expected 00", ifc.issue);
        end
        compared++;
        if (ifc.tmo_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_tmo: got %b expected 0", ifc.tmo_err);
        end
        compared++;
        if (ifc.rndxv !== 2'b00 || ifc.issued !== '0 || ifc.rndx !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_rndx: got v=%b i=%h r=%h expected all zero",
                     ifc.rndxv, ifc.issued, ifc.rndx);
        end
        ifc.brrdy = 32'h1;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL preReset_issue: got %b expected 01", ifc.issue);
        end
        rst = 1'b1;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b00 || ifc.bs_idle_oh !== 2'b11 || ifc.rndxv !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL midReset: got issue=%b idle=%b v=%b expected 00/11/00",
                     ifc.issue, ifc.bs_idle_oh, ifc.rndxv);
        end
        rst       = 1'b0;
        ifc.brrdy = '0;
    endtask

    task automatic test_oldest_first();
        applyReset();
        ifc.head  = 5'd4;
        ifc.brrdy = (32'h1 << 2) | (32'h1 << 5) | (32'h1 << 9);
        stepClock();
        compared++;
        if (ifc.issue !== 2'b11 || ifc.rndx[0] !== 5'd5 || ifc.rndx[1] !== 5'd9) begin
            mismatched++;
            $display("[TB] FAIL oldest_pick: got issue=%b r0=%0d r1=%0d expected 11/5/9",
                     ifc.issue, ifc.rndx[0], ifc.rndx[1]);
        end
        compared++;
        if (ifc.issued !== ((32'h1 << 5) | (32'h1 << 9))) begin
            mismatched++;
            $display("[TB] FAIL oldest_issued: got %h expected %h", ifc.issued,
                     (32'h1 << 5) | (32'h1 << 9));
        end
        ifc.brrdy = 32'h1 << 2;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b00 || ifc.issued !== '0) begin
            mismatched++;
            $display("[TB] FAIL oldest_noIdle: got issue=%b issued=%h expected 0", ifc.issue, ifc.issued);
        end
        ifc.bs_done = 2'b01;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b00 || ifc.bs_idle_oh !== 2'b01 || ifc.rndxv !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL oldest_doneCycle: got issue=%b idle=%b v=%b expected 00/01/10",
                     ifc.issue, ifc.bs_idle_oh, ifc.rndxv);
        end
        ifc.bs_done = 2'b00;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b01 || ifc.rndx[0] !== 5'd2) begin
            mismatched++;
            $display("[TB] FAIL oldest_waiter: got issue=%b r0=%0d expected 01/2", ifc.issue, ifc.rndx[0]);
        end
        ifc.brrdy = '0;
    endtask

    task automatic test_wrap();
        applyReset();
        ifc.brrdy = 32'h1 << 10;
        stepClock();
        ifc.head  = 5'd30;
        ifc.brrdy = (32'h1 << 1) | (32'h1 << 31);
        stepClock();
        compared++;
        if (ifc.issue !== 2'b10 || ifc.rndx[1] !== 5'd31) begin
            mismatched++;
            $display("[TB] FAIL wrap_pick: got issue=%b r1=%0d expected 10/31", ifc.issue, ifc.rndx[1]);
        end
        ifc.brrdy = 32'h1 << 1;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL wrap_wait: got issue=%b expected 00", ifc.issue);
        end
        ifc.bs_done = 2'b10;
        stepClock();
        ifc.bs_done = 2'b00;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b10 || ifc.rndx[1] !== 5'd1) begin
            mismatched++;
            $display("[TB] FAIL wrap_younger: got issue=%b r1=%0d expected 10/1", ifc.issue, ifc.rndx[1]);
        end
        ifc.brrdy = '0;
    endtask

    task automatic test_no_double_issue();
        int issueCnt;
        int issuedCnt;
        issueCnt  = 0;
        issuedCnt = 0;
        applyReset();
        for (int c = 0; c < 5; c++) begin
            ifc.brrdy = (c < 3) ? (32'h1 << 7) : 32'h0;
            stepClock();
            if (ifc.issue !== 2'b00) issueCnt++;
            if (ifc.issued[7] === 1'b1) issuedCnt++;
        end
        compared++;
        if (issueCnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL dbl_issueCount: got %0d expected 1", issueCnt);
        end
        compared++;
        if (issuedCnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL dbl_issuedCount: got %0d expected 1", issuedCnt);
        end
        compared++;
        if (ifc.rndx[0] !== 5'd7 || ifc.bs_idle_oh !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL dbl_owner: got r0=%0d idle=%b expected 7/10", ifc.rndx[0], ifc.bs_idle_oh);
        end
    endtask

    task automatic test_done_flush_race();
        applyReset();
        ifc.brrdy = 32'h3;
        stepClock();
        ifc.brrdy   = 32'h1 << 3;
        ifc.flush   = 1'b1;
        ifc.bs_done = 2'b01;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b00 || ifc.issued !== '0 || ifc.bs_idle_oh !== 2'b11 || ifc.rndxv !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL race_flush: got issue=%b issued=%h idle=%b v=%b expected 00/0/11/00",
                     ifc.issue, ifc.issued, ifc.bs_idle_oh, ifc.rndxv);
        end
        ifc.flush   = 1'b0;
        ifc.bs_done = 2'b00;
        stepClock();
        compared++;
        if (ifc.issue !== 2'b01 || ifc.rndx[0] !== 5'd3) begin
            mismatched++;
            $display("[TB] FAIL race_reissue: got issue=%b r0=%0d expected 01/3", ifc.issue, ifc.rndx[0]);
        end
        ifc.brrdy = '0;
    endtask

    task automatic test_watchdog();
        int tmoCnt;
        int firstTmo;
        logic idleAtTmo;
        tmoCnt    = 0;
        firstTmo  = -1;
        idleAtTmo = 1'b0;
        applyReset();
        ifc.brrdy = 32'h1 << 6;
        stepClock();
        ifc.brrdy = '0;
        compared++;
        if (ifc.issue !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL wdog_issue: got %b expected 01", ifc.issue);
        end
        for (int i = 1; i <= 80; i++) begin
            stepClock();
            if (i == TMO - 1) begin
                compared++;
                if (ifc.bs_idle_oh[0] !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL wdog_early: got idle0=%b expected 0 at cycle %0d", ifc.bs_idle_oh[0], i);
                end
            end
            if (ifc.tmo_err === 1'b1) begin
                tmoCnt++;
                if (firstTmo < 0) begin
                    firstTmo  = i;
                    idleAtTmo = ifc.bs_idle_oh[0];
                end
            end
        end
        compared++;
        if (tmoCnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL wdog_pulses: got %0d expected 1", tmoCnt);
        end
        compared++;
        if (firstTmo !== TMO) begin
            mismatched++;
            $display("[TB] FAIL wdog_cycle: got %0d expected %0d", firstTmo, TMO);
        end
        compared++;
        if (idleAtTmo !== 1'b1 || ifc.bs_idle_oh !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL wdog_idle: got atTmo=%b end=%b expected 1/11", idleAtTmo, ifc.bs_idle_oh);
        end
    endtask

    // Reference: stations are a pool; each cycle walk the ROB from head in age
    // order and hand ready entries not owned by a busy station to idle stations.
    task automatic test_random();
        logic                mBusy [NBS];
        rob_ndx_t            mOwn  [NBS];
        int                  mAge  [NBS];
        rob_ndx_t            mRndx [NBS];
        logic [ROB-1:0]      readySet, retire, retireOld, owned, rdy, expIssued;
        logic [NBS-1:0]      expIssue, expBusy, dn;
        logic                expTmo, fl;
        rob_ndx_t            h, pick, idx;
        int                  idleQ[$];
        int                  s;

        applyReset();
        for (int k = 0; k < NBS; k++) begin
            mBusy[k] = 1'b0;
            mOwn[k]  = '0;
            mAge[k]  = 0;
            mRndx[k] = '0;
        end
        readySet  = '0;
        retire    = '0;
        retireOld = '0;
        h         = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            readySet  = readySet & ~retireOld;
            retireOld = retire;
            repeat ($urandom_range(0, 2)) begin
                pick = rob_ndx_t'($urandom_range(0, ROB - 1));
                readySet[pick] = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) h = rob_ndx_t'($urandom);
            fl = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < NBS; k++) dn[k] = ($urandom_range(0, 3) == 0);
            rdy         = readySet;
            ifc.head    = h;
            ifc.brrdy   = rdy;
            ifc.flush   = fl;
            ifc.bs_done = dn;

            expIssue  = '0;
            expIssued = '0;
            expTmo    = 1'b0;
            retire    = '0;
            if (fl) begin
                for (int k = 0; k < NBS; k++) mBusy[k] = 1'b0;
                readySet  = '0;
                retireOld = '0;
            end else begin
                owned = '0;
                idleQ.delete();
                for (int k = 0; k < NBS; k++) begin
                    if (mBusy[k]) owned[mOwn[k]] = 1'b1;
                    else idleQ.push_back(k);
                end
                for (int k = 0; k < NBS; k++) begin
                    if (mBusy[k]) begin
                        if (dn[k]) mBusy[k] = 1'b0;
                        else if (mAge[k] + 1 == TMO) begin
                            mBusy[k] = 1'b0;
                            expTmo   = 1'b1;
                        end else mAge[k] = mAge[k] + 1;
                    end
                end
                for (int off = 0; off < ROB; off++) begin
                    idx = rob_ndx_t'((int'(h) + off) % ROB);
                    if (idleQ.size() > 0 && rdy[idx] && !owned[idx]) begin
                        s           = idleQ.pop_front();
                        mBusy[s]    = 1'b1;
                        mOwn[s]     = idx;
                        mAge[s]     = 0;
                        mRndx[s]    = idx;
                        expIssue[s] = 1'b1;
                        expIssued[idx] = 1'b1;
                    end
                end
                retire = expIssued;
            end
            for (int k = 0; k < NBS; k++) expBusy[k] = mBusy[k];

            stepClock();

            compared++;
            if (ifc.issue !== expIssue) begin
                mismatched++;
                $display("[TB] FAIL rnd_issue cyc %0d: got %b expected %b", cyc, ifc.issue, expIssue);
            end
            compared++;
            if (ifc.issued !== expIssued) begin
                mismatched++;
                $display("[TB] FAIL rnd_issued cyc %0d: got %h expected %h", cyc, ifc.issued, expIssued);
            end
            for (int k = 0; k < NBS; k++) begin
                compared++;
                if (ifc.rndx[k] !== mRndx[k]) begin
                    mismatched++;
                    $display("[TB] FAIL rnd_rndx%0d cyc %0d: got %0d expected %0d", k, cyc, ifc.rndx[k], mRndx[k]);
                end
            end
            compared++;
            if (ifc.rndxv !== expBusy || ifc.bs_idle_oh !== ~expBusy) begin
                mismatched++;
                $display("[TB] FAIL rnd_state cyc %0d: got v=%b idle=%b expected v=%b idle=%b",
                         cyc, ifc.rndxv, ifc.bs_idle_oh, expBusy, ~expBusy);
            end
            compared++;
            if (ifc.tmo_err !== expTmo) begin
                mismatched++;
                $display("[TB] FAIL rnd_tmo cyc %0d: got %b expected %b", cyc, ifc.tmo_err, expTmo);
            end
        end
        ifc.brrdy   = '0;
        ifc.flush   = 1'b0;
        ifc.bs_done = '0;
    endtask

    initial begin
        ifc.head    = '0;
        ifc.brrdy   = '0;
        ifc.flush   = 1'b0;
        ifc.bs_done = '0;
        test_reset();
        test_oldest_first();
        test_wrap();
        test_no_double_issue();
        test_done_flush_race();
        test_watchdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stark_branch_scheduler.md
# stark_branch_scheduler

Issue scheduler for the branch-station pool. Each cycle it picks the oldest ready branch entries in the ROB, starting at the ROB head with wrap-around, and assigns each to an idle branch station. It also tracks per-station occupancy with a small FSM and a watchdog. It drives the `issue`, `rndx`, `rndxv` and `bs_idle_oh` inputs of each `Stark_branch_station` instance.

## Interface
Parameters:
- `NBS`, 2: number of branch stations (1..4).
- `ROB_ENTRIES`, 32: ROB depth; power of two.
- `TMO`, 63: watchdog limit in cycles a station may stay busy.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `head` in `rob_ndx_t`: index of the oldest ROB entry.
- `brrdy` in `ROB_ENTRIES`: entry is a valid branch, not yet issued, all args ready.
- `flush` in 1: pipeline stomp; abort all stations.
- `bs_done` in `NBS`: one-cycle pulse from station k when it finishes.
- `issue` out `NBS`: one-cycle issue strobe to station k.
- `rndx` out `NBS` x `rob_ndx_t`: ROB index issued to station k.
- `rndxv` out `NBS`: `rndx[k]` valid.
- `bs_idle_oh` out `NBS`: station k is idle, to that station.
- `issued` out `ROB_ENTRIES`: one-hot-per-station mask of entries issued this cycle, used by the ROB to set the issued flag.
- `tmo_err` out 1: one-cycle pulse when any station hits the watchdog.

## Operation
- **Per-station FSM:** `IDLE` → `BUSY` on issue to that station. `BUSY` → `IDLE` on `bs_done[k]`, on `flush`, or on watchdog expiry.
- **Watchdog:** each station has a 6-bit counter, cleared on issue and incremented in `BUSY`. When it reaches `TMO`: pulse `tmo_err`, force the station to `IDLE`, and do not issue to that station in the same cycle.
- **Age selection:**
  - Rotate `brrdy` and the pending mask right by `head`.
  - Mask out the pending entries.
  - Priority-encode the lowest set bit for the oldest entry; repeat with it masked to get up to `NBS` candidates.
  - Add `head` back modulo `ROB_ENTRIES`.
- **Station assignment:** the oldest candidate goes to the lowest-numbered `IDLE` station, the next oldest to the next idle station, and so on. Surplus candidates wait.
- **Pending mask:** entries issued in cycle t are held in a pending mask for cycle t+1. This covers ROB issued-flag latency, so the same entry is never issued twice.
- **`flush`:** all stations go `IDLE`, the pending mask clears, and there is no issue that cycle.
- `bs_idle_oh[k] = 1` when station k is `IDLE`. This is registered.

## Timing
- **Reset:**
  - Stations: all `IDLE`, counters 0.
  - `issue`, `rndxv`, `issued`, `tmo_err` = 0; `rndx` = 0; pending mask = 0.
  - `bs_idle_oh` = all ones.
- **Latency:** a `brrdy` bit set in cycle t produces `issue`, `rndx` and `rndxv` registered at t+1. The station is `BUSY` from t+1.
- `issue[k]` is a single-cycle pulse. `rndx[k]` and `rndxv[k]` hold until the next issue to that station; `rndxv` drops on `flush` or `bs_done`.
- **`bs_done[k]` and a ready entry in the same cycle:** the station is considered busy for selection that cycle; the earliest reissue to it is t+1.
- **`flush` with `bs_done` in the same cycle:** `flush` dominates. There is no double effect.
- **`rst` mid-operation:** immediate return to reset state on the next edge. Outstanding entries are not reported.
- **Wrap-around:** with `head` = 30, an entry at index 1 is younger than index 31.
- **No idle station:** no issue, no `issued` bits. Candidates are recomputed each cycle.
- **Empty `brrdy`:** outputs idle, counters of busy stations continue.

## Structure
- `bs_state_t` (`BS_IDLE`, `BS_BUSY`) goes in `Stark_pkg`.
- `rob_ndx_t` comes from `cpu_types_pkg`.
- Sub-module `stark_age_select`: combinational rotate, mask and find-first-N for `ROB_ENTRIES` wide vectors, returning `NBS` indices plus valid bits.
- Top level holds the station FSMs, watchdogs, pending mask and output registers.

## Test plan
- **Reset:** assert `rst` 2 cycles, release → `bs_idle_oh` = 2'b11, `issue` = 0, `tmo_err` = 0.
- **Oldest-first:** `head` = 4, `brrdy` bits {2,5,9} → next cycle `issue` = 2'b11, `rndx[0]` = 5, `rndx[1]` = 9; entry 2 waits.
- **Wrap-around:** `head` = 30, `brrdy` {1,31}, one station idle → `rndx` = 31; entry 1 issued after `bs_done`.
- **No double issue:** `brrdy[7]` held high 3 cycles, NBS = 2 → entry 7 issued exactly once; `issued[7]` pulses once.
- **Done/flush race:** `bs_done[0]` and `flush` in the same cycle with `brrdy[3]` → no issue that cycle, both stations `IDLE`, entry 3 issued the following cycle.
- **Watchdog:** issue to station 0, never pulse `bs_done` → after 63 busy cycles `tmo_err` pulses once and `bs_idle_oh[0]` returns to 1.
